// File: rtl/bus_ctrl_pkg.sv
// Shared bus-controller types: port count, port id / port bit-vector types, arbiter states.
package bus_ctrl_pkg;

   localparam int unsigned CPUS          = 4;
   localparam int unsigned CPU_ID_LENGTH = (CPUS > 1) ? $clog2(CPUS) : 1;

   typedef logic [CPU_ID_LENGTH-1:0] cpuid_t;
   typedef logic [CPUS-1:0]          cpus_bitvec_t;

   typedef enum logic [1:0] {
      ARB_IDLE,
      ARB_OFFER,
      ARB_BUSY,
      ARB_RELEASE
   } arb_state_t;

   function automatic cpus_bitvec_t cpu_onehot(input cpuid_t id);
      return CPUS'(1) << id;
   endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin search: first set request bit at or after start, wrapping at N (any N).
module rr_pick #(
   parameter int unsigned N = 4,
   parameter int unsigned W = 2
) (
   input  logic [N-1:0] req,
   input  logic [W-1:0] start,
   output logic         found_c,
   output logic [W-1:0] idx_c
);

   int unsigned pos;

   always_comb begin
      found_c = 1'b0;
      idx_c   = '0;
      pos     = 0;
      for (int unsigned k = 0; k < N; k++) begin
         pos = 32'(start) + k;
         if (pos >= N) pos = pos - N;
         if (!found_c && req[pos]) begin
            found_c = 1'b1;
            idx_c   = W'(pos);
         end
      end
   end

endmodule

// File: rtl/bus_req_arbiter.sv
// Picks the next L1 port for the coherence bus: starved reads, then writebacks, then reads,
// round-robin within each class, holding the grant until the bus controller finishes it.
module bus_req_arbiter
   import bus_ctrl_pkg::*;
#(
   parameter int unsigned STARVE_LIMIT = 8
) (
   input  logic                     CLK,
   input  logic                     RST,
   input  logic [CPUS-1:0]          req_ren,
   input  logic [CPUS-1:0]          req_wen,
   input  logic                     grant_ack,
   input  logic                     txn_done,
   output logic                     grant_valid,
   output logic [CPU_ID_LENGTH-1:0] grant_id,
   output logic                     grant_write,
   output logic [CPUS-1:0]          wait_mask
);

   localparam int unsigned      CNT_W   = $clog2(STARVE_LIMIT + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

   arb_state_t       state_q, state_d;
   logic             grant_valid_q, grant_valid_d;
   cpuid_t           grant_id_q, grant_id_d;
   logic             grant_write_q, grant_write_d;
   cpuid_t           rr_ptr_q, rr_ptr_d;
   logic [CNT_W-1:0] wait_cnt_q [CPUS];

   cpus_bitvec_t req_any, starved;
   logic         st_found, wr_found, rd_found;
   cpuid_t       st_idx, wr_idx, rd_idx, win_id;
   logic         win_write, granted_req, grant_evt, done_evt;

   assign req_any = req_ren | req_wen;

   always_comb begin
      starved = '0;
      for (int unsigned i = 0; i < CPUS; i++)
         starved[i] = req_any[i] && (wait_cnt_q[i] == CNT_MAX);
   end

   rr_pick #(.N(CPUS), .W(CPU_ID_LENGTH)) u_pick_starved (
      .req(starved), .start(rr_ptr_q), .found_c(st_found), .idx_c(st_idx));
   rr_pick #(.N(CPUS), .W(CPU_ID_LENGTH)) u_pick_write (
      .req(req_wen), .start(rr_ptr_q), .found_c(wr_found), .idx_c(wr_idx));
   rr_pick #(.N(CPUS), .W(CPU_ID_LENGTH)) u_pick_read (
      .req(req_ren), .start(rr_ptr_q), .found_c(rd_found), .idx_c(rd_idx));

   // A starved port that also holds a writeback is still presented as a writeback.
   always_comb begin
      win_id    = rd_idx;
      win_write = 1'b0;
      if (st_found) begin
         win_id    = st_idx;
         win_write = req_wen[st_idx];
      end else if (wr_found) begin
         win_id    = wr_idx;
         win_write = 1'b1;
      end else if (rd_found) begin
         win_id    = rd_idx;
      end
   end

   assign granted_req = grant_write_q ? req_wen[grant_id_q] : req_ren[grant_id_q];

   always_ff @(posedge CLK) begin
      if (RST) state_q <= ARB_IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d       = state_q;
      grant_valid_d = grant_valid_q;
      grant_id_d    = grant_id_q;
      grant_write_d = grant_write_q;
      grant_evt     = 1'b0;
      done_evt      = 1'b0;
      case (state_q)
         ARB_IDLE: begin
            if (|req_any) begin
               state_d       = ARB_OFFER;
               grant_valid_d = 1'b1;
               grant_id_d    = win_id;
               grant_write_d = win_write;
            end
         end
         ARB_OFFER: begin
            if (grant_ack) begin
               grant_evt = 1'b1;
               if (txn_done) begin
                  done_evt      = 1'b1;
                  state_d       = ARB_RELEASE;
                  grant_valid_d = 1'b0;
               end else begin
                  state_d = ARB_BUSY;
               end
            end else if (!granted_req) begin
               state_d       = ARB_IDLE;
               grant_valid_d = 1'b0;
            end
         end
         ARB_BUSY: begin
            if (txn_done) begin
               done_evt      = 1'b1;
               state_d       = ARB_RELEASE;
               grant_valid_d = 1'b0;
            end
         end
         ARB_RELEASE: state_d = ARB_IDLE;
         default: begin
            state_d       = ARB_IDLE;
            grant_valid_d = 1'b0;
         end
      endcase
   end

   // Explicit wrap so non-power-of-two port counts rotate correctly.
   always_comb begin
      rr_ptr_d = rr_ptr_q;
      if (done_evt)
         rr_ptr_d = (grant_id_q == CPU_ID_LENGTH'(CPUS - 1)) ? '0
                                                             : grant_id_q + CPU_ID_LENGTH'(1);
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         grant_valid_q <= 1'b0;
         grant_id_q    <= '0;
         grant_write_q <= 1'b0;
         rr_ptr_q      <= '0;
      end else begin
         grant_valid_q <= grant_valid_d;
         grant_id_q    <= grant_id_d;
         grant_write_q <= grant_write_d;
         rr_ptr_q      <= rr_ptr_d;
      end
   end

   // Starvation counters: clear on grant or idle port, saturate at the limit.
   always_ff @(posedge CLK) begin
      for (int unsigned i = 0; i < CPUS; i++) begin
         if (RST) begin
            wait_cnt_q[i] <= '0;
         end else if (!req_any[i] || (grant_evt && grant_id_q == CPU_ID_LENGTH'(i))) begin
            wait_cnt_q[i] <= '0;
         end else if (done_evt && grant_id_q != CPU_ID_LENGTH'(i) && wait_cnt_q[i] != CNT_MAX) begin
            wait_cnt_q[i] <= wait_cnt_q[i] + CNT_W'(1);
         end
      end
   end

   assign grant_valid = grant_valid_q;
   assign grant_id    = grant_id_q;
   assign grant_write = grant_write_q;
   assign wait_mask   = req_any & ~(grant_valid_q ? cpu_onehot(grant_id_q) : '0);

endmodule
